// File: rtl/hlsm_driver_if.sv
// hlsm_driver_if
// Bundles every non-clock/reset signal of hlsm_driver.
//   in_*    : operand-set handshake from the producer (in_valid/in_ready, in_a..in_g)
//   hlsm_*  : start/operands to the downstream datapath FSM, done/results back
//   out_*   : result handshake to the consumer (out_valid/out_ready, out_k, out_l, out_err)
//   busy, job_count : status
// Modport master is the driver side; slave is the environment (producer, FSM, consumer).
interface hlsm_driver_if #(
   parameter int unsigned W = 16
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a, in_b, in_c, in_d, in_e, in_f, in_g;
   logic         hlsm_start;
   logic [W-1:0] hlsm_a, hlsm_b, hlsm_c, hlsm_d, hlsm_e, hlsm_f, hlsm_g;
   logic         hlsm_done;
   logic [W-1:0] hlsm_k, hlsm_l;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_k, out_l;
   logic         out_err;
   logic         busy;
   logic [7:0]   job_count;

   modport master (
      input  in_valid, in_a, in_b, in_c, in_d, in_e, in_f, in_g,
      input  hlsm_done, hlsm_k, hlsm_l, out_ready,
      output in_ready, hlsm_start,
      output hlsm_a, hlsm_b, hlsm_c, hlsm_d, hlsm_e, hlsm_f, hlsm_g,
      output out_valid, out_k, out_l, out_err, busy, job_count
   );

   modport slave (
      output in_valid, in_a, in_b, in_c, in_d, in_e, in_f, in_g,
      output hlsm_done, hlsm_k, hlsm_l, out_ready,
      input  in_ready, hlsm_start,
      input  hlsm_a, hlsm_b, hlsm_c, hlsm_d, hlsm_e, hlsm_f, hlsm_g,
      input  out_valid, out_k, out_l, out_err, busy, job_count
   );
endinterface

// File: rtl/hlsm_driver.sv
// hlsm_driver
// Accepts an operand set, holds it on hlsm_a..g with hlsm_start high while the
// downstream FSM computes k=(a*b+c*d)/e and l=f/g, captures the results on Done
// (or aborts with out_err after TIMEOUT cycles), then drops start for one GAP
// cycle so the FSM parks before the next job.
// Ports:
//   Clk : clock, all state updates on posedge
//   Rst : asynchronous active-low reset
//   bus : hlsm_driver_if.master (input/FSM/output handshakes and status)
module hlsm_driver #(
   parameter int unsigned W       = 16,
   parameter int unsigned TIMEOUT = 31
) (
   input  logic          Clk,
   input  logic          Rst,
   hlsm_driver_if.master bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [7:0] TMO = TIMEOUT[7:0];

   state_t       state;
   logic [7:0]   cnt;
   logic         start_q;
   logic [W-1:0] op_q [7];
   logic [W-1:0] k_q, l_q;
   logic         err_q;
   logic         ov_q;
   logic [7:0]   jobs_q;

   logic ready;
   logic accept;
   logic drain;

   // A pending result may be drained on the same edge a new job is accepted.
   assign ready  = (state == IDLE) && (!ov_q || bus.out_ready);
   assign accept = bus.in_valid && ready;
   assign drain  = ov_q && bus.out_ready;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state   <= IDLE;
         cnt     <= '0;
         start_q <= 1'b0;
         for (int unsigned i = 0; i < 7; i++) begin
            op_q[i] <= '0;
         end
         k_q     <= '0;
         l_q     <= '0;
         err_q   <= 1'b0;
         ov_q    <= 1'b0;
         jobs_q  <= '0;
      end else begin
         if (drain) begin
            ov_q <= 1'b0;
         end
         unique case (state)
            IDLE: begin
               if (accept) begin
                  op_q[0] <= bus.in_a;
                  op_q[1] <= bus.in_b;
                  op_q[2] <= bus.in_c;
                  op_q[3] <= bus.in_d;
                  op_q[4] <= bus.in_e;
                  op_q[5] <= bus.in_f;
                  op_q[6] <= bus.in_g;
                  cnt     <= '0;
                  start_q <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               if (cnt != 8'hFF) begin
                  cnt <= cnt + 8'd1;
               end
               // At cnt=0 Done is still the previous job's registered value.
               // Done is checked before the timeout so it wins a tie.
               if ((cnt != 8'd0) && bus.hlsm_done) begin
                  k_q     <= bus.hlsm_k;
                  l_q     <= bus.hlsm_l;
                  err_q   <= 1'b0;
                  ov_q    <= 1'b1;
                  jobs_q  <= jobs_q + 8'd1;
                  start_q <= 1'b0;
                  state   <= GAP;
               end else if (cnt == TMO) begin
                  k_q     <= '0;
                  l_q     <= '0;
                  err_q   <= 1'b1;
                  ov_q    <= 1'b1;
                  start_q <= 1'b0;
                  state   <= GAP;
               end
            end
            GAP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready   = ready;
   assign bus.hlsm_start = start_q;
   assign bus.hlsm_a     = op_q[0];
   assign bus.hlsm_b     = op_q[1];
   assign bus.hlsm_c     = op_q[2];
   assign bus.hlsm_d     = op_q[3];
   assign bus.hlsm_e     = op_q[4];
   assign bus.hlsm_f     = op_q[5];
   assign bus.hlsm_g     = op_q[6];
   assign bus.out_valid  = ov_q;
   assign bus.out_k      = k_q;
   assign bus.out_l      = l_q;
   assign bus.out_err    = err_q;
   assign bus.busy       = (state != IDLE);
   assign bus.job_count  = jobs_q;
endmodule

// File: tb/tb_hlsm_driver.sv
// tb_hlsm_driver
// Scoreboard bench for hlsm_driver: the stimulus process pushes the expected
// result (value, error flag, job count, arrival cycle) for every accepted job;
// a monitor pops and compares whenever out_valid rises. A behavioural FSM model
// with programmable latency answers hlsm_start.
module tb_hlsm_driver;
   localparam int W   = 16;
   localparam int TMO = 31;

   logic Clk = 1'b0;
   logic Rst = 1'b0;
   always #5 Clk = ~Clk;

   hlsm_driver_if #(.W(W)) bus ();

   hlsm_driver #(.W(W), .TIMEOUT(TMO)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   typedef struct {
      logic [W-1:0] k;
      logic [W-1:0] l;
      logic         err;
      logic [7:0]   jobs;
      int           cyc;
   } exp_t;

   exp_t         sbq[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           exp_jobs = 0;
   logic [W-1:0] cur_ops [7];

   always @(posedge Clk) cyc <= cyc + 1;

   function automatic int sx(input logic [W-1:0] v);
      return int'($signed(v));
   endfunction

   // Downstream FSM model: Done rises 'mlat' cycles into the job and stays
   // high afterwards, so it is stale at the start of the next job.
   int           mlat = 12;
   int           mcnt = 0;
   logic         mdone = 1'b1;
   logic [W-1:0] mk = '0;
   logic [W-1:0] ml = '0;
   assign bus.hlsm_done = mdone;
   assign bus.hlsm_k    = mk;
   assign bus.hlsm_l    = ml;

   always @(posedge Clk) begin
      if (bus.hlsm_start) begin
         mcnt <= mcnt + 1;
         if (mcnt + 1 >= mlat) begin
            mdone <= 1'b1;
            mk <= (sx(bus.hlsm_e) == 0) ? '0 :
                  W'((sx(bus.hlsm_a) * sx(bus.hlsm_b) + sx(bus.hlsm_c) * sx(bus.hlsm_d)) / sx(bus.hlsm_e));
            ml <= (sx(bus.hlsm_g) == 0) ? '0 : W'(sx(bus.hlsm_f) / sx(bus.hlsm_g));
         end else begin
            mdone <= 1'b0;
            mk    <= W'($urandom);
            ml    <= W'($urandom);
         end
      end else begin
         mcnt <= 0;
      end
   end

   // Monitor: samples 2 time units after each rising edge.
   initial begin
      exp_t         e;
      logic         prev_ov = 1'b0;
      logic [W-1:0] pk = '0, pl = '0;
      logic         perr = 1'b0;
      forever begin
         @(posedge Clk);
         #2;
         if (!Rst) begin
            prev_ov = 1'b0;
            continue;
         end
         if (bus.out_valid && !prev_ov) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_result: out_valid=1 at cycle %0d, expected no result", cyc);
            end else begin
               e = sbq.pop_front();
               if (bus.out_k !== e.k || bus.out_l !== e.l || bus.out_err !== e.err) begin
                  errors++;
                  $display("FAIL result_value: got k=%0d l=%0d err=%0b expected k=%0d l=%0d err=%0b",
                           $signed(bus.out_k), $signed(bus.out_l), bus.out_err,
                           $signed(e.k), $signed(e.l), e.err);
               end
               checks++;
               if (bus.job_count !== e.jobs) begin
                  errors++;
                  $display("FAIL job_count: got %0d expected %0d", bus.job_count, e.jobs);
               end
               checks++;
               if (cyc != e.cyc) begin
                  errors++;
                  $display("FAIL latency: out_valid at cycle %0d expected cycle %0d", cyc, e.cyc);
               end
            end
         end
         if (prev_ov) begin
            checks++;
            if (bus.out_valid !== !bus.out_ready || bus.out_k !== pk || bus.out_l !== pl ||
                bus.out_err !== perr) begin
               errors++;
               $display("FAIL result_hold: got v=%0b k=%0d l=%0d err=%0b expected v=%0b k=%0d l=%0d err=%0b",
                        bus.out_valid, $signed(bus.out_k), $signed(bus.out_l), bus.out_err,
                        !bus.out_ready, $signed(pk), $signed(pl), perr);
            end
         end
         if (bus.out_valid && !bus.out_ready) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin
               errors++;
               $display("FAIL in_ready_stall: got %0b expected 0", bus.in_ready);
            end
         end
         if (bus.hlsm_start) begin
            checks++;
            if ({bus.hlsm_a, bus.hlsm_b, bus.hlsm_c, bus.hlsm_d, bus.hlsm_e, bus.hlsm_f, bus.hlsm_g} !==
                {cur_ops[0], cur_ops[1], cur_ops[2], cur_ops[3], cur_ops[4], cur_ops[5], cur_ops[6]} ||
                bus.busy !== 1'b1) begin
               errors++;
               $display("FAIL hlsm_operands: got a=%0h g=%0h busy=%0b expected a=%0h g=%0h busy=1",
                        bus.hlsm_a, bus.hlsm_g, bus.busy, cur_ops[0], cur_ops[6]);
            end
         end
         prev_ov = bus.out_valid;
         pk      = bus.out_k;
         pl      = bus.out_l;
         perr    = bus.out_err;
      end
   end

   // Offers an operand set from a negedge and waits (bounded) for acceptance.
   // Returns just before the accepting edge; acc is that edge's cycle index.
   task automatic offer(input int op[7], output int ok, output int tries, output int acc);
      bus.in_a = W'(op[0]); bus.in_b = W'(op[1]); bus.in_c = W'(op[2]); bus.in_d = W'(op[3]);
      bus.in_e = W'(op[4]); bus.in_f = W'(op[5]); bus.in_g = W'(op[6]);
      bus.in_valid = 1'b1;
      ok = 0; tries = 0; acc = 0;
      for (int i = 0; i < 200 && ok == 0; i++) begin
         #1;
         if (bus.in_ready) begin
            ok  = 1;
            acc = cyc + 1;
         end else begin
            tries++;
            @(negedge Clk);
         end
      end
      checks++;
      if (ok == 0) begin
         errors++;
         $display("FAIL accept_timeout: in_ready stayed 0, expected an accept");
         bus.in_valid = 1'b0;
      end else begin
         for (int i = 0; i < 7; i++) cur_ops[i] = W'(op[i]);
      end
   endtask

   // Runs one job: lat = model Done latency, stall = cycles out_ready is held
   // low once the result appears. Ends at a negedge with out_ready=1.
   task automatic run_job(input int op[7], input int lat, input int stall, output int tries);
      int   ok, acc, eff, got;
      exp_t e;
      mlat = lat;
      offer(op, ok, tries, acc);
      if (ok == 0) return;
      eff   = (lat <= TMO) ? lat : TMO;
      e.err = (lat > TMO);
      e.k   = e.err ? '0 : W'((op[0] * op[1] + op[2] * op[3]) / op[4]);
      e.l   = e.err ? '0 : W'(op[5] / op[6]);
      if (!e.err) exp_jobs = (exp_jobs + 1) % 256;
      e.jobs = 8'(exp_jobs);
      e.cyc  = acc + eff + 1;
      sbq.push_back(e);
      @(negedge Clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = (stall == 0);
      got = 0;
      for (int i = 0; i < 300; i++) begin
         if (bus.out_valid) begin
            got = 1;
            break;
         end
         @(negedge Clk);
      end
      checks++;
      if (got == 0) begin
         errors++;
         $display("FAIL result_timeout: out_valid=0 after 300 cycles, expected 1");
      end
      repeat (stall) @(negedge Clk);
      bus.out_ready = 1'b1;
   endtask

   task automatic check_val(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   initial begin
      int op[7];
      int tries, ok, acc;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      bus.in_a = '0; bus.in_b = '0; bus.in_c = '0; bus.in_d = '0;
      bus.in_e = '0; bus.in_f = '0; bus.in_g = '0;

      repeat (3) @(negedge Clk);
      check_val("reset_outputs",
                int'({bus.hlsm_start, bus.out_valid, bus.out_err, bus.busy}) + int'(bus.job_count) +
                int'(bus.out_k) + int'(bus.out_l) + int'(bus.hlsm_a), 0);
      check_val("reset_in_ready", int'(bus.in_ready), 1);

      // Basic job, stale Done at entry, accept on first edge after release.
      Rst = 1'b1;
      op = '{3, 4, 5, 6, 7, 100, 9};
      run_job(op, 12, 0, tries);
      check_val("first_accept_tries", tries, 0);
      check_val("job1_k", sx(bus.out_k), 6);
      check_val("job1_l", sx(bus.out_l), 11);
      check_val("job1_count", int'(bus.job_count), 1);

      op = '{-2, 3, 1, 1, 5, -7, 2};
      run_job(op, 12, 0, tries);
      check_val("job2_k", sx(bus.out_k), -1);
      check_val("job2_l", sx(bus.out_l), -3);
      check_val("job2_count", int'(bus.job_count), 2);

      // Done never arrives: timeout abort.
      op = '{1, 2, 3, 4, 5, 6, 7};
      run_job(op, 1000, 0, tries);
      check_val("timeout_err", int'(bus.out_err), 1);
      check_val("timeout_start_low", int'(bus.hlsm_start), 0);
      check_val("timeout_count", int'(bus.job_count), 2);

      // Done exactly at the timeout cycle wins.
      op = '{10, 10, 2, 5, 3, 50, -4};
      run_job(op, TMO, 0, tries);
      check_val("tie_err", int'(bus.out_err), 0);

      // Backpressure for 20 cycles, then drain and accept on the same edge.
      op = '{-9, 8, 7, -6, 5, 44, 3};
      run_job(op, 12, 20, tries);
      op = '{11, -12, 13, 14, -15, 16, 17};
      run_job(op, 5, 0, tries);
      check_val("same_edge_accept_tries", tries, 0);

      for (int n = 0; n < 25; n++) begin
         for (int i = 0; i < 7; i++) op[i] = int'($urandom_range(200)) - 100;
         if (op[4] == 0) op[4] = 1;
         if (op[6] == 0) op[6] = -1;
         run_job(op, int'($urandom_range(40, 1)), int'($urandom_range(3)), tries);
      end

      // Reset in the middle of a job (cnt=5).
      repeat (3) @(negedge Clk);
      mlat = 12;
      op = '{5, 5, 5, 5, 5, 5, 5};
      offer(op, ok, tries, acc);
      @(posedge Clk);
      #1 bus.in_valid = 1'b0;
      repeat (5) @(posedge Clk);
      #3 Rst = 1'b0;
      #1;
      check_val("async_reset_start", int'(bus.hlsm_start), 0);
      check_val("async_reset_busy", int'(bus.busy), 0);
      check_val("async_reset_outs",
                int'({bus.out_valid, bus.out_err}) + int'(bus.job_count) + int'(bus.out_k) +
                int'(bus.out_l) + int'(bus.hlsm_a) + int'(bus.hlsm_g), 0);
      sbq.delete();
      exp_jobs = 0;
      @(negedge Clk);
      @(negedge Clk);
      Rst = 1'b1;
      repeat (30) @(negedge Clk);
      check_val("no_result_after_abort", int'(bus.out_valid), 0);

      op = '{2, 2, 2, 2, 2, 9, 4};
      run_job(op, 12, 0, tries);
      check_val("post_reset_count", int'(bus.job_count), 1);

      repeat (10) @(negedge Clk);
      check_val("pending_results", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
